parity_frame_acc: RTL and testbench
===================================

Name: parity_frame_acc

Overview:
- Parametrised successor to the team's 3-input combinational parity generator.
- Accumulates parity over a stream of WIDTH-bit words grouped into frames with valid/ready handshakes.
- At end of frame, emits the frame parity in even or odd mode, the frame length, and a mismatch flag against a transmitted parity bit.
- Sits between a serial/byte receiver and the frame consumer as an integrity checker.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CNT_W, 8, width of the frame word counter and out_len.
- ERR_CNT_W, 16, width of the error counter (used only with the optional feature).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the first beat of each frame.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  data word.
- in_last  in  1  marks the final word of a frame.
- in_par  in  1  expected parity bit, meaningful only on the last beat.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts the result.
- out_parity  out  1  computed frame parity.
- out_err  out  1  1 when out_parity != the in_par captured on the last beat.
- out_len  out  CNT_W  number of words in the frame; saturating.
- err_cnt  out  ERR_CNT_W  frame error count; present only with PARITY_ERR_CNT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; acc=0; cnt=0; mode_r=0.
- Output reset values: in_ready=0 while rst_n is low, 1 from the first clock after release; out_valid=0; out_parity=0; out_err=0; out_len=0; err_cnt=0.
- Beat: a word is accepted when in_valid && in_ready.
- FSM state IDLE:
  - in_ready=1.
  - Accepted non-last beat: acc<=^in_data; cnt<=1; mode_r<=odd_mode; go to ACC.
  - Accepted last beat: single-word frame; go directly to RESULT.
- FSM state ACC:
  - in_ready=1.
  - Accepted beat: acc<=acc^(^in_data); cnt<=cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - On in_last, go to RESULT.
- Result computation on the last accepted beat:
  - out_parity <= acc^(^in_data)^mode_eff, where mode_eff=odd_mode for a single-word frame, else mode_r.
  - out_err <= that value ^ in_par.
  - out_len <= saturated cnt+1.
  - out_valid <= 1.
- Latency: result visible the cycle after the last beat.
- FSM state RESULT:
  - in_ready=0, so no beats are accepted.
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready: out_valid<=0; acc<=0; cnt<=0; go to IDLE. in_ready returns to 1 the following cycle.
- in_valid=0 mid-frame: state and acc are held; bubbles do not affect the result.
- in_data and in_par are ignored when in_valid=0 or in_ready=0.
- odd_mode changes mid-frame have no effect on the current frame.
- Reset mid-frame or in RESULT: frame discarded, all outputs return to their reset values immediately; no partial result is emitted.
- Even mode: out_parity equals the XOR of all frame bits. Odd mode: its inverse.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined:
  - err_cnt port exists.
  - err_cnt increments by 1 on each result handshake (out_valid && out_ready) with out_err=1.
  - Saturates at all-ones; reset to 0 by rst_n.
- Undefined: err_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single-word frame: in_data=8'h07, in_last=1, in_par=1, odd_mode=0 -> next cycle out_valid=1, out_parity=1, out_err=0, out_len=1.
- 3-word even frame 8'h01, 8'h03, 8'hFF, in_par=0 -> out_parity=1, out_err=1, out_len=3; with the feature enabled, err_cnt=1 after the handshake.
- Same frame with odd_mode=1 on the first beat and odd_mode toggled mid-frame -> out_parity=0; in_par=0 gives out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> outputs stable, in_ready=0, and offered words are not consumed. out_ready=1 -> IDLE and next frame accepted normally.
- in_valid bubbles (valid every other cycle) over a 4-word frame of 8'h80 -> out_parity=0, out_len=4.
- CNT_W=2 with a 6-word frame -> out_len=3 (saturated). Separately, rst_n pulse mid-frame -> out_valid stays 0; the next frame computes from a cleared accumulator.

Source files
------------

// File: rtl/parity_frame_acc.sv
// parity_frame_acc: accumulates parity over a framed word stream and reports
// the frame parity (even/odd), the frame length and a mismatch flag against
// the transmitted parity bit.
//
// Optional feature macro: PARITY_ERR_CNT_EN (adds the err_cnt port/counter).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   odd_mode          0 = even, 1 = odd parity; sampled on the first beat
//   in_valid/in_ready input word handshake
//   in_data           WIDTH-bit data word
//   in_last           final word of a frame
//   in_par            transmitted parity bit (last beat only)
//   out_valid/out_ready result handshake
//   out_parity        computed frame parity
//   out_err           out_parity != captured in_par
//   out_len           words in the frame, saturating at 2^CNT_W-1
//   err_cnt           saturating count of erroneous frames (feature only)
module parity_frame_acc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic [CNT_W-1:0] out_len
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Elaboration-time parameter sanity check.
  if (WIDTH < 1 || CNT_W < 1 || ERR_CNT_W < 1) begin : g_param_check
    $error("parity_frame_acc: WIDTH, CNT_W and ERR_CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_RESULT
  } state_t;

  state_t           state, state_d;
  logic             acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             mode_r, mode_d;
  logic             in_ready_d;
  logic             out_valid_d, out_parity_d, out_err_d;
  logic [CNT_W-1:0] out_len_d;

  logic             beat;
  logic             word_par;
  logic             mode_eff;
  logic             frame_par;
  logic [CNT_W-1:0] cnt_sat;

  assign beat      = in_valid && in_ready;
  assign word_par  = ^in_data;
  // A single-word frame has no earlier beat to have latched the mode.
  assign mode_eff  = (state == S_IDLE) ? odd_mode : mode_r;
  assign frame_par = acc ^ word_par ^ mode_eff;
  assign cnt_sat   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= 1'b0;
      cnt        <= '0;
      mode_r     <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
      out_len    <= '0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      cnt        <= cnt_d;
      mode_r     <= mode_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_parity <= out_parity_d;
      out_err    <= out_err_d;
      out_len    <= out_len_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state;
    acc_d        = acc;
    cnt_d        = cnt;
    mode_d       = mode_r;
    out_valid_d  = out_valid;
    out_parity_d = out_parity;
    out_err_d    = out_err;
    out_len_d    = out_len;

    case (state)
      S_IDLE: begin
        if (beat) begin
          if (in_last) begin
            out_valid_d  = 1'b1;
            out_parity_d = frame_par;
            out_err_d    = frame_par ^ in_par;
            out_len_d    = cnt_sat;
            state_d      = S_RESULT;
          end else begin
            acc_d   = word_par;
            cnt_d   = CNT_W'(1);
            mode_d  = odd_mode;
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (beat) begin
          acc_d = acc ^ word_par;
          cnt_d = cnt_sat;
          if (in_last) begin
            out_valid_d  = 1'b1;
            out_parity_d = frame_par;
            out_err_d    = frame_par ^ in_par;
            out_len_d    = cnt_sat;
            state_d      = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d != S_RESULT);
  end

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_d;

  // Saturating count of result handshakes that carried an error.
  always_comb begin
    err_cnt_d = err_cnt;
    if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
      err_cnt_d = err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_acc.sv
// Directed self-checking bench for parity_frame_acc. A second instance with
// CNT_W=2 shares all stimulus so the length saturation can be observed.
module tb_parity_frame_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       odd_mode;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_par;
  logic       out_ready;

  logic       in_ready, out_valid, out_parity, out_err;
  logic [7:0] out_len;
  logic       in_ready_s, out_valid_s, out_parity_s, out_err_s;
  logic [1:0] out_len_s;
`ifdef PARITY_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [15:0] err_cnt_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_acc #(.WIDTH(8), .CNT_W(8), .ERR_CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_err(out_err), .out_len(out_len)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  parity_frame_acc #(.WIDTH(8), .CNT_W(2), .ERR_CNT_W(16)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_last(in_last), .in_par(in_par),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_parity(out_parity_s), .out_err(out_err_s), .out_len(out_len_s)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(err_cnt_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one word at the negedge; it is accepted on the following posedge.
  task automatic send(input logic [7:0] d, input logic last, input logic par, input logic mode);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last; in_par = par; odd_mode = mode;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'hFF; in_par = 1'b1;
  endtask

  // Check the pending result at the next negedge.
  task automatic expect_result(input string tag, input logic par, input logic err, input logic [7:0] len);
    @(negedge clk);
    check({tag, "_valid"},  32'(out_valid),  32'd1);
    check({tag, "_parity"}, 32'(out_parity), 32'(par));
    check({tag, "_err"},    32'(out_err),    32'(err));
    check({tag, "_len"},    32'(out_len),    32'(len));
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; odd_mode = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; in_par = 1'b0; out_ready = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_parity", 32'(out_parity), 32'd0);
    check("rst_out_err",    32'(out_err),    32'd0);
    check("rst_out_len",    32'(out_len),    32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single-word frame 0x07 (three ones), even, in_par=1.
    send(8'h07, 1'b1, 1'b1, 1'b0);
    expect_result("single", 1'b1, 1'b0, 8'd1);
    take_result("single");

    // 3-word even frame: 1 ^ 0 ^ 0 = 1, in_par=0 -> error.
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    expect_result("even3", 1'b1, 1'b1, 8'd3);
    take_result("even3");
`ifdef PARITY_ERR_CNT_EN
    check("even3_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Same frame, odd mode latched on beat 1, toggled mid-frame.
    send(8'h01, 1'b0, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    expect_result("odd3", 1'b0, 1'b0, 8'd3);

    // Backpressure: five cycles with words offered but not consumed.
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1; in_par = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    32'(out_valid),  32'd1);
      check("bp_parity",   32'(out_parity), 32'd0);
      check("bp_len",      32'(out_len),    32'd3);
      check("bp_in_ready", 32'(in_ready),   32'd0);
    end
    in_valid = 1'b0;
    take_result("bp");
`ifdef PARITY_ERR_CNT_EN
    check("bp_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Bubbles: four 0x80 words, valid every other cycle, junk in gaps.
    for (int i = 0; i < 4; i++) begin
      send(8'h80, (i == 3), 1'b0, 1'b0);
      if (i != 3) begin
        @(negedge clk);
        in_data = 8'h01; in_last = 1'b1;
      end
    end
    expect_result("bubble", 1'b0, 1'b0, 8'd4);
    take_result("bubble");

    // Six-word frame: main instance counts 6, CNT_W=2 instance saturates at 3.
    for (int i = 0; i < 6; i++) send(8'h01, (i == 5), 1'b0, 1'b0);
    expect_result("six", 1'b0, 1'b0, 8'd6);
    check("six_sat_len",   32'(out_len_s),   32'd3);
    check("six_sat_valid", 32'(out_valid_s), 32'd1);
    take_result("six");

    // Single-word odd frame: mode taken from the live odd_mode input.
    send(8'h00, 1'b1, 1'b1, 1'b1);
    expect_result("single_odd", 1'b1, 1'b0, 8'd1);
    take_result("single_odd");

    // Reset mid-frame: no result, next frame starts clean.
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid",    32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    send(8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0, 1'b0);
    expect_result("after_rst", 1'b1, 1'b1, 8'd2);
    take_result("after_rst");
`ifdef PARITY_ERR_CNT_EN
    check("after_rst_err_cnt", 32'(err_cnt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
